// File: rtl/decomp_job_ctrl.sv
// decomp_job_ctrl: job/block completion controller for the decompressor core.
// Tracks block and job drains behind a quiescence window and guards drains with a watchdog.
`default_nettype none

module decomp_job_ctrl #(
   parameter int NUM_PARSER    = 6,
   parameter int NUM_RAM       = 16,
   parameter int SETTLE_CYCLES = 6,
   parameter int TIMEOUT       = 65535,
   parameter int CNT_W         = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic                  tf_empty,
   input  logic [NUM_PARSER-1:0] ps_finish,
   input  logic [NUM_PARSER-1:0] ps_empty,
   input  logic [NUM_RAM-1:0]    ram_empty,
   input  logic                  page_input_finish,
   input  logic                  cl_finish,
   output logic                  idle,
   output logic                  job_decompressed,
   output logic                  block_finish,
   output logic [CNT_W-1:0]      block_count,
   output logic                  timeout_err
);

   localparam int WD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_RUN       = 3'd1,
      S_BLK_DRAIN = 3'd2,
      S_JOB_DRAIN = 3'd3,
      S_DONE      = 3'd4,
      S_ERR       = 3'd5
   } state_t;

   state_t                state, state_nxt;
   logic                  all_empty_r;
   logic [7:0]            settle_cnt;
   logic                  quiet;
   logic                  page_flag;
   logic                  blk_pend;
   logic [NUM_PARSER-1:0] ps_finish_q;
   logic [WD_W-1:0]       wd_cnt;
   logic                  fin_rise;
   logic                  in_drain;
   logic                  wd_expired;
   logic                  start_acc;
   logic                  blk_done;
   logic                  blk_clear;

   assign fin_rise   = |(ps_finish & ~ps_finish_q);
   assign quiet      = (settle_cnt == 8'(SETTLE_CYCLES));
   assign in_drain   = (state == S_BLK_DRAIN) || (state == S_JOB_DRAIN);
   assign wd_expired = (TIMEOUT != 0) && in_drain && (wd_cnt == WD_W'(TIMEOUT - 1));

   always_comb begin
      state_nxt = state;
      start_acc = 1'b0;
      blk_done  = 1'b0;
      blk_clear = 1'b0;
      case (state)
         S_IDLE: begin
            if (start) begin
               state_nxt = S_RUN;
               start_acc = 1'b1;
            end
         end
         S_RUN: begin
            // A pending block drain always goes ahead of the job drain.
            if (blk_pend) begin
               state_nxt = S_BLK_DRAIN;
               blk_clear = 1'b1;
            end else if (page_flag && tf_empty) begin
               state_nxt = S_JOB_DRAIN;
            end
         end
         S_BLK_DRAIN: begin
            if (quiet) begin
               blk_done  = 1'b1;
               state_nxt = S_RUN;
            end else if (wd_expired) begin
               state_nxt = S_ERR;
            end
         end
         S_JOB_DRAIN: begin
            if (quiet && !blk_pend) begin
               state_nxt = S_DONE;
            end else if (quiet) begin
               blk_done  = 1'b1;
               blk_clear = 1'b1;
            end else if (wd_expired) begin
               state_nxt = S_ERR;
            end
         end
         S_DONE:  if (cl_finish) state_nxt = S_IDLE;
         S_ERR:   if (cl_finish) state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state            <= S_IDLE;
         all_empty_r      <= 1'b0;
         settle_cnt       <= 8'd0;
         page_flag        <= 1'b0;
         blk_pend         <= 1'b0;
         ps_finish_q      <= '0;
         wd_cnt           <= '0;
         idle             <= 1'b1;
         job_decompressed <= 1'b0;
         block_finish     <= 1'b0;
         block_count      <= '0;
         timeout_err      <= 1'b0;
      end else begin
         state       <= state_nxt;
         all_empty_r <= (&ps_empty) & (&ram_empty) & tf_empty;
         ps_finish_q <= ps_finish;

         if (!all_empty_r)
            settle_cnt <= 8'd0;
         else if (!quiet)
            settle_cnt <= settle_cnt + 8'd1;

         if (start_acc || state == S_IDLE)
            page_flag <= 1'b0;
         else if (page_input_finish && (state == S_RUN || in_drain))
            page_flag <= 1'b1;

         // A new rising edge wins over consumption so no block is lost.
         if (fin_rise)
            blk_pend <= 1'b1;
         else if (blk_clear || start_acc)
            blk_pend <= 1'b0;

         if ((state_nxt != state) &&
             (state_nxt == S_BLK_DRAIN || state_nxt == S_JOB_DRAIN))
            wd_cnt <= '0;
         else if (in_drain)
            wd_cnt <= wd_cnt + WD_W'(1);

         idle             <= (state_nxt == S_IDLE);
         job_decompressed <= (state_nxt == S_DONE);
         block_finish     <= blk_done;

         if (start_acc)
            block_count <= '0;
         else if (blk_done)
            block_count <= block_count + CNT_W'(1);

         if (start_acc)
            timeout_err <= 1'b0;
         else if (state_nxt == S_ERR)
            timeout_err <= 1'b1;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_decomp_job_ctrl.sv
// tb_decomp_job_ctrl: scoreboard bench; expected completion events are queued by stimulus
// and matched by a monitor against block_finish / job_decompressed / timeout_err events.
`default_nettype none

module tb_decomp_job_ctrl;

   localparam int NP = 6;
   localparam int NR = 16;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic          tf_empty;
   logic [NP-1:0] ps_finish;
   logic [NP-1:0] ps_empty;
   logic [NR-1:0] ram_empty;
   logic          pif;
   logic          cl_finish;
   logic          idle;
   logic          job_decompressed;
   logic          block_finish;
   logic [15:0]   block_count;
   logic          timeout_err;

   decomp_job_ctrl #(
      .NUM_PARSER(NP), .NUM_RAM(NR), .SETTLE_CYCLES(6), .TIMEOUT(50), .CNT_W(16)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .tf_empty(tf_empty),
      .ps_finish(ps_finish), .ps_empty(ps_empty), .ram_empty(ram_empty),
      .page_input_finish(pif), .cl_finish(cl_finish), .idle(idle),
      .job_decompressed(job_decompressed), .block_finish(block_finish),
      .block_count(block_count), .timeout_err(timeout_err)
   );

   always #5 clk = ~clk;

   // kind: 1 = block_finish pulse, 2 = job_decompressed rise, 3 = timeout_err rise
   typedef struct {
      int kind;
      int cyc;
      int cnt;
   } ev_t;

   ev_t  exp_q[$];
   int   cyc = 0;
   int   errors = 0;
   int   checks = 0;
   logic prev_job = 1'b0;
   logic prev_terr = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input int kind, input int at, input int cnt);
      ev_t e;
      e.kind = kind;
      e.cyc  = at;
      e.cnt  = cnt;
      exp_q.push_back(e);
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, expv, cyc);
      end
   endtask

   task automatic see_event(input int kind);
      ev_t e;
      checks++;
      if (exp_q.size() == 0) begin
         errors++;
         $display("FAIL unexpected_event: got kind %0d at cycle %0d, expected none", kind, cyc);
      end else begin
         e = exp_q.pop_front();
         if (e.kind != kind || e.cyc != cyc || (kind == 1 && e.cnt != int'(block_count))) begin
            errors++;
            $display("FAIL event: got kind %0d cycle %0d count %0d, expected kind %0d cycle %0d count %0d",
                     kind, cyc, block_count, e.kind, e.cyc, e.cnt);
         end
      end
   endtask

   always @(negedge clk) begin
      if (!rst) begin
         if (block_finish) see_event(1);
         if (job_decompressed && !prev_job) see_event(2);
         if (timeout_err && !prev_terr) see_event(3);
      end
      prev_job  = job_decompressed;
      prev_terr = timeout_err;
   end

   task automatic begin_job();
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("idle_after_start", idle, 0);
   endtask

   task automatic finish_job();
      cl_finish = 1'b1;
      tick();
      cl_finish = 1'b0;
      chk("idle_after_cl", idle, 1);
      chk("job_after_cl", job_decompressed, 0);
   endtask

   // Busy parsers, rising ps_finish[idx], then all lanes empty inside BLK_DRAIN.
   task automatic drain_block(input int idx, input int cnt, input bit hold);
      ps_empty = '0;
      tick();
      ps_finish[idx] = 1'b1;
      tick();
      if (!hold) ps_finish[idx] = 1'b0;
      tick();
      ps_empty = '1;
      push(1, cyc + 8, cnt);
      repeat (10) tick();
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; tf_empty = 1'b1; ps_finish = '0;
      ps_empty = '1; ram_empty = '1; pif = 1'b0; cl_finish = 1'b0;
      tick(); tick();
      chk("rst_idle", idle, 1);
      chk("rst_job", job_decompressed, 0);
      chk("rst_bf", block_finish, 0);
      chk("rst_count", block_count, 0);
      chk("rst_terr", timeout_err, 0);
      rst = 1'b0;
      tick();

      // Basic job: all empty after edge k -> job_decompressed at k+8
      begin_job();
      tf_empty = 1'b0; ps_empty = '0; ram_empty = '0;
      repeat (3) tick();
      pif = 1'b1; tick(); pif = 1'b0;
      repeat (3) tick();
      tf_empty = 1'b1; ps_empty = '1; ram_empty = '1;
      push(2, cyc + 8, 0);
      repeat (10) tick();
      chk("basic_job", job_decompressed, 1);
      finish_job();

      // Glitch four cycles into the window restarts it -> k+13
      begin_job();
      tf_empty = 1'b0; ps_empty = '0; ram_empty = '0;
      repeat (2) tick();
      pif = 1'b1; tick(); pif = 1'b0;
      tick();
      tf_empty = 1'b1; ps_empty = '1; ram_empty = '1;
      push(2, cyc + 13, 0);
      repeat (4) tick();
      ram_empty[3] = 1'b0; tick(); ram_empty[3] = 1'b1;
      repeat (12) tick();
      chk("glitch_job", job_decompressed, 1);
      finish_job();

      // Three blocks, last with ps_finish held high; then already-quiet job
      begin_job();
      drain_block(2, 1, 1'b0);
      drain_block(2, 2, 1'b0);
      drain_block(2, 3, 1'b1);
      pif = 1'b1;
      push(2, cyc + 3, 0);
      tick(); pif = 1'b0;
      repeat (8) tick();
      chk("blocks_count", block_count, 3);
      chk("blocks_job", job_decompressed, 1);
      finish_job();
      ps_finish = '0;
      tick();

      // Block edge and last page in the same cycle
      begin_job();
      tf_empty = 1'b0; ps_empty[0] = 1'b0;
      repeat (3) tick();
      ps_finish[1] = 1'b1; pif = 1'b1; tf_empty = 1'b1; ps_empty = '1;
      push(1, cyc + 8, 1);
      push(2, cyc + 10, 0);
      tick();
      ps_finish[1] = 1'b0; pif = 1'b0;
      repeat (11) tick();
      chk("simul_job", job_decompressed, 1);
      chk("simul_count", block_count, 1);
      start = 1'b1; tick(); start = 1'b0;
      chk("busy_start_idle", idle, 0);
      chk("busy_start_job", job_decompressed, 1);
      chk("busy_start_count", block_count, 1);
      start = 1'b1; cl_finish = 1'b1; tick(); start = 1'b0; cl_finish = 1'b0;
      chk("cl_beats_start_idle", idle, 1);
      chk("cl_beats_start_job", job_decompressed, 0);

      // Watchdog: ps_empty[0] stuck in JOB_DRAIN -> ERR 50 cycles after entry
      begin_job();
      ps_empty[0] = 1'b0;
      repeat (2) tick();
      pif = 1'b1;
      push(3, cyc + 52, 0);
      tick(); pif = 1'b0;
      repeat (56) tick();
      chk("wd_terr", timeout_err, 1);
      chk("wd_idle", idle, 0);
      chk("wd_job", job_decompressed, 0);
      finish_job();
      chk("wd_terr_sticky", timeout_err, 1);
      begin_job();
      chk("wd_terr_cleared", timeout_err, 0);

      // Reset in JOB_DRAIN with a nonzero block count
      drain_block(3, 1, 1'b0);
      ps_empty[0] = 1'b0;
      repeat (2) tick();
      pif = 1'b1; tick(); pif = 1'b0;
      repeat (3) tick();
      start = 1'b1; tick(); start = 1'b0;
      chk("drain_start_count", block_count, 1);
      chk("drain_start_idle", idle, 0);
      #1 rst = 1'b1;
      #1;
      chk("mid_rst_idle", idle, 1);
      chk("mid_rst_job", job_decompressed, 0);
      chk("mid_rst_bf", block_finish, 0);
      chk("mid_rst_count", block_count, 0);
      chk("mid_rst_terr", timeout_err, 0);
      tick();
      rst = 1'b0;
      repeat (5) tick();
      chk("post_rst_idle", idle, 1);

      while (exp_q.size() != 0) begin
         ev_t e;
         e = exp_q.pop_front();
         checks++;
         errors++;
         $display("FAIL missing_event: got none, expected kind %0d at cycle %0d", e.kind, e.cyc);
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/decomp_job_ctrl.md
# decomp_job_ctrl

Job-level completion controller for the decompressor core, sitting between the token FIFO, parser array, history RAM banks and the page-clean logic. It is the parametrised successor of the fixed 6-parser/16-RAM job controller. It adds configurable parser and RAM counts, a programmable quiescence window, per-block completion pulses with a block counter, and a drain watchdog that reports a hung pipeline instead of waiting forever.

## Interface
- NUM_PARSER, 6, number of parser lanes.
- NUM_RAM, 16, number of history RAM banks.
- SETTLE_CYCLES, 6, consecutive all-empty cycles required before a drain is complete (1..255).
- TIMEOUT, 65535, max cycles spent in a drain state before error; 0 disables the watchdog.
- CNT_W, 16, width of block_count.

- clk, in, 1, single clock, all logic rising-edge.
- rst, in, 1, asynchronous active-high reset.
- start, in, 1, job start pulse; honoured only in IDLE.
- tf_empty, in, 1, token FIFO empty.
- ps_finish, in, NUM_PARSER, per-parser end-of-block flag (level or pulse).
- ps_empty, in, NUM_PARSER, per-parser empty.
- ram_empty, in, NUM_RAM, per-bank write queue empty.
- page_input_finish, in, 1, last input page delivered (pulse).
- cl_finish, in, 1, page clean done (pulse).
- idle, out, 1, controller ready for a new job.
- job_decompressed, out, 1, level; job output fully drained, held until cl_finish.
- block_finish, out, 1, one-cycle pulse per drained block.
- block_count, out, CNT_W, blocks completed in current job, wraps at 2^CNT_W.
- timeout_err, out, 1, sticky watchdog error.

## Operation
- all_empty_r <= &ps_empty & &ram_empty & tf_empty, registered every cycle.
- settle_cnt (8 b): cleared when all_empty_r=0. Otherwise it increments, saturating at SETTLE_CYCLES. quiet = (settle_cnt == SETTLE_CYCLES). It runs in every state.
- page_flag: set on page_input_finish in RUN or drain states; cleared on start accepted and in IDLE.
- blk_pend: set on a rising edge of any ps_finish bit (previous-cycle register vs current). Cleared when RUN consumes it. A rising edge in the same cycle as consumption re-sets it.
- FSM states:
  - IDLE: idle=1. start -> RUN; clear block_count, timeout_err, page_flag, blk_pend.
  - RUN: if blk_pend -> BLK_DRAIN (block has priority). Else if page_flag & tf_empty -> JOB_DRAIN.
  - BLK_DRAIN: when quiet, pulse block_finish, increment block_count, -> RUN.
  - JOB_DRAIN: when quiet & !blk_pend, set job_decompressed -> DONE. When quiet & blk_pend, pulse block_finish, increment block_count, clear blk_pend, stay.
  - DONE: hold job_decompressed. On cl_finish clear it -> IDLE.
  - ERR: timeout_err=1. On cl_finish -> IDLE; timeout_err stays until next accepted start.
- Watchdog: wd_cnt clears on entry to BLK_DRAIN/JOB_DRAIN and increments while in them. If TIMEOUT!=0 and wd_cnt==TIMEOUT-1 without exit -> ERR.
- start outside IDLE is ignored. cl_finish outside DONE/ERR is ignored.
- Unused state encodings -> IDLE.

## Timing
- Reset values: idle=1, job_decompressed=0, block_finish=0, block_count=0, timeout_err=0, state IDLE, settle_cnt=0, flags 0.
- start at edge N: idle=0 after edge N.
- Drain latency: inputs all empty and sampled at edge t -> all_empty_r at t; settle_cnt reaches SETTLE_CYCLES at t+SETTLE_CYCLES; output (job_decompressed or block_finish) registered at edge t+SETTLE_CYCLES+1. If the FSM is already in the drain state, that is SETTLE_CYCLES+2 edges after inputs go empty (8 with default).
- A single non-empty cycle inside the window restarts the count.
- cl_finish at edge M: job_decompressed=0 and idle=1 after edge M.
- start and cl_finish in the same cycle in DONE: cl_finish wins, start dropped.
- Reset mid-job returns to IDLE immediately, asynchronously, with no block_finish or job_decompressed pulse.

## Test plan
- Basic job: start, feed tokens, page_input_finish, all empties high from cycle 100 -> job_decompressed rises at cycle 108 (SETTLE=6); cl_finish at 120 -> idle=1 at 121.
- Glitch: all empty except ram_empty[3] low for 1 cycle at cycle 104 -> job_decompressed delayed to cycle 113.
- Blocks: three ps_finish[2] rising edges each followed by a drain -> three block_finish pulses, block_count=3, then job completes; ps_finish held high produces only one pulse.
- Simultaneous: ps_finish edge and page_input_finish with tf_empty in the same cycle -> block_finish pulse first, then job_decompressed; block_count=1.
- Watchdog: TIMEOUT=50, ps_empty[0] stuck low in JOB_DRAIN -> timeout_err=1 at cycle 50 after entry; cl_finish -> idle=1; next start clears timeout_err.
- Reset: rst asserted in JOB_DRAIN -> all outputs at reset values the same cycle; start while busy is ignored (block_count unchanged).
